// File: rtl/vector_pkg.sv
// Shared types for the vector add/subtract datapath: FSM states, opcodes, width helper.
// No logic; no latency; no backpressure.
// Imported by vector_addsub and addsub_cell.
package vector_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Ceiling log2; log2(1) = 0.
    function automatic int log2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/addsub_cell.sv
// One signed add/sub lane with range check; wraps, or clamps under VECTOR_ADDSUB_SATURATE_EN.
// Latency: purely combinational.
// Backpressure: none; the parent sequences the lanes.
module addsub_cell
    import vector_pkg::*;
#(
    parameter int A_W = 8,
    parameter int B_W = 8,
    parameter int R_W = 8
) (
    input  logic [A_W-1:0] a_el,
    input  logic [B_W-1:0] b_el,
    input  logic           op,
    output logic [R_W-1:0] sum,
    output logic           oor
);

    localparam int W  = ((A_W > B_W) ? A_W : B_W) + 1;
    // Work wide enough for both the exact result and the result width.
    localparam int WX = (W > R_W) ? W : R_W;

    logic signed [WX-1:0] a_x;
    logic signed [WX-1:0] b_x;
    logic signed [WX-1:0] res;
    logic [WX-R_W:0]      top_bits;

    always_comb begin
        a_x      = WX'($signed(a_el));
        b_x      = WX'($signed(b_el));
        res      = (op == OP_SUB) ? (a_x - b_x) : (a_x + b_x);
        // In range iff every bit from the result sign position up is a sign copy.
        top_bits = res[WX-1:R_W-1];
        oor      = !((&top_bits) || !(|top_bits));
`ifdef VECTOR_ADDSUB_SATURATE_EN
        if (oor) begin
            sum = res[WX-1] ? {1'b1, {(R_W-1){1'b0}}} : {1'b0, {(R_W-1){1'b1}}};
        end else begin
            sum = res[R_W-1:0];
        end
`else
        sum = res[R_W-1:0];
`endif
    end

endmodule

// File: rtl/vector_addsub.sv
// Multi-lane signed vector a+b / a-b with per-element overflow flags (VECTOR_ADDSUB_SATURATE_EN clamps).
// Latency: ceil(VECTOR_LEN/TILING) edges from second operand accept to result_valid.
// Backpressure: operand readies drop once captured; result held in DONE until result_ready.
module vector_addsub
    import vector_pkg::*;
#(
    parameter int VECTOR_LEN        = 5,
    parameter int A_CELL_WIDTH      = 8,
    parameter int B_CELL_WIDTH      = 8,
    parameter int RESULT_CELL_WIDTH = 8,
    parameter int TILING            = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [VECTOR_LEN*A_CELL_WIDTH-1:0]    a,
    input  logic                                  op,
    input  logic                                  a_valid,
    output logic                                  a_ready,
    input  logic [VECTOR_LEN*B_CELL_WIDTH-1:0]    b,
    input  logic                                  b_valid,
    output logic                                  b_ready,
    output logic [VECTOR_LEN*RESULT_CELL_WIDTH-1:0] result,
    output logic                                  result_valid,
    input  logic                                  result_ready,
    output logic                                  error,
    output logic [VECTOR_LEN-1:0]                 error_mask
);

    localparam int AW = A_CELL_WIDTH;
    localparam int BW = B_CELL_WIDTH;
    localparam int RW = RESULT_CELL_WIDTH;
    localparam int CW = log2(VECTOR_LEN) + 1;

    state_t                    state_q, state_d;
    logic                      a_set_q, a_set_d;
    logic                      b_set_q, b_set_d;
    logic                      op_q, op_d;
    logic [VECTOR_LEN*AW-1:0]  a_buf_q, a_buf_d;
    logic [VECTOR_LEN*BW-1:0]  b_buf_q, b_buf_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [VECTOR_LEN*RW-1:0]  result_q, result_d;
    logic [VECTOR_LEN-1:0]     mask_q, mask_d;

    logic                      a_fire;
    logic                      b_fire;
    logic [TILING*AW-1:0]      lane_a;
    logic [TILING*BW-1:0]      lane_b;
    logic [TILING*RW-1:0]      lane_sum;
    logic [TILING-1:0]         lane_oor;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            a_set_q  <= 1'b0;
            b_set_q  <= 1'b0;
            op_q     <= OP_ADD;
            a_buf_q  <= '0;
            b_buf_q  <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            mask_q   <= '0;
        end else begin
            state_q  <= state_d;
            a_set_q  <= a_set_d;
            b_set_q  <= b_set_d;
            op_q     <= op_d;
            a_buf_q  <= a_buf_d;
            b_buf_q  <= b_buf_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            mask_q   <= mask_d;
        end
    end

    // Steer elements counter..counter+TILING-1 onto the lanes; lanes past the end see zero.
    always_comb begin
        lane_a = '0;
        lane_b = '0;
        for (int t = 0; t < TILING; t++) begin
            for (int e = 0; e < VECTOR_LEN; e++) begin
                if (int'(cnt_q) + t == e) begin
                    lane_a[t*AW +: AW] = a_buf_q[e*AW +: AW];
                    lane_b[t*BW +: BW] = b_buf_q[e*BW +: BW];
                end
            end
        end
    end

    for (genvar g = 0; g < TILING; g++) begin : g_lane
        addsub_cell #(
            .A_W (AW),
            .B_W (BW),
            .R_W (RW)
        ) u_cell (
            .a_el (lane_a[g*AW +: AW]),
            .b_el (lane_b[g*BW +: BW]),
            .op   (op_q),
            .sum  (lane_sum[g*RW +: RW]),
            .oor  (lane_oor[g])
        );
    end

    always_comb begin
        state_d  = state_q;
        a_set_d  = a_set_q;
        b_set_d  = b_set_q;
        op_d     = op_q;
        a_buf_d  = a_buf_q;
        b_buf_d  = b_buf_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        mask_d   = mask_q;
        a_fire   = a_valid && a_ready;
        b_fire   = b_valid && b_ready;
        case (state_q)
            IDLE: begin
                if (a_fire) begin
                    a_buf_d = a;
                    op_d    = op;
                    a_set_d = 1'b1;
                end
                if (b_fire) begin
                    b_buf_d = b;
                    b_set_d = 1'b1;
                end
                if ((a_set_q || a_fire) && (b_set_q || b_fire)) begin
                    state_d  = CALC;
                    cnt_d    = '0;
                    mask_d   = '0;
                    result_d = '0;
                end
            end
            CALC: begin
                for (int e = 0; e < VECTOR_LEN; e++) begin
                    for (int t = 0; t < TILING; t++) begin
                        if (int'(cnt_q) + t == e) begin
                            result_d[e*RW +: RW] = lane_sum[t*RW +: RW];
                            mask_d[e]            = lane_oor[t];
                        end
                    end
                end
                cnt_d = cnt_q + CW'(TILING);
                if (int'(cnt_q) + TILING >= VECTOR_LEN) state_d = DONE;
            end
            DONE: begin
                if (result_ready) begin
                    state_d = IDLE;
                    a_set_d = 1'b0;
                    b_set_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        a_ready      = (state_q == IDLE) && !a_set_q;
        b_ready      = (state_q == IDLE) && !b_set_q;
        result_valid = (state_q == DONE);
        result       = result_q;
        error_mask   = mask_q;
        error        = |mask_q;
    end

endmodule
